mux_sel_pipe: RTL and testbench
===============================

# mux_sel_pipe

Parametrised, registered NIN:1 operand selector for the arithmetic datapath, generalising the fixed 3:1 × 16-bit bitwise mux to any width and input count. Adds a valid/ready handshake with a two-entry skid buffer for full throughput under backpressure, a round-robin select mode, and out-of-range select detection. It sits between the operand sources (register file, bypass, constant) and pipelined arithmetic units such as adders and multipliers.

## Interface
- WIDTH, 16, data bits per input
- NIN, 3, number of inputs (2..16)
- SELW, $clog2(NIN), select width (derived; not overridden)
- clk  input  1  clock; all state on rising edge
- reset_n  input  1  asynchronous, active-low reset
- din  input  NIN*WIDTH  packed inputs; input i = din[i*WIDTH +: WIDTH]
- sel  input  SELW  input index (mode 0)
- rr_mode  input  1  0 = explicit select, 1 = round-robin
- in_valid  input  1  upstream word valid
- in_ready  output  1  block can accept
- dout  output  WIDTH  selected data
- out_sel  output  SELW  effective index used for dout
- out_err  output  1  dout came from an out-of-range select
- out_valid  output  1  dout/out_sel/out_err valid
- out_ready  input  1  downstream accepts

## Operation
- Accept = in_valid & in_ready. Fire = out_valid & out_ready.
- Effective select: eff = sel when rr_mode=0; eff = rr_ptr when rr_mode=1.
- Selected word = din[eff*WIDTH +: WIDTH] if eff < NIN; otherwise all-zero with err=1. err is always 0 in rr_mode.
- Each accepted entry captures {word, eff, err} at the accept edge. din, sel and rr_mode are sampled only on accept.
- rr_ptr: SELW-bit register, reset 0. It increments on every accept while rr_mode=1 and wraps NIN-1 → 0. It holds while rr_mode=0 and keeps its value across mode switches.
- Storage: output register (OR) plus skid register (SK). Occupancy states:
  - EMPTY (out_valid=0, in_ready=1): accept → ONE, entry written to OR.
  - ONE (out_valid=1, in_ready=1):
    - accept & fire → ONE, new entry into OR.
    - accept & !fire → TWO, new entry into SK.
    - !accept & fire → EMPTY.
    - neither → ONE, OR holds.
  - TWO (out_valid=1, in_ready=0): fire → ONE, SK moves to OR. Otherwise hold.
- in_ready = !SK-valid, driven directly from a register with no combinational path from out_ready.
- Order is strictly preserved. No entry is dropped or duplicated.
- While out_valid=1 and out_ready=0, dout, out_sel and out_err stay stable.

## Timing
- Reset (async assert, sync-safe deassert):
  - State EMPTY; out_valid=0, in_ready=1.
  - dout=0, out_sel=0, out_err=0, rr_ptr=0.
- Reset asserted mid-operation discards OR and SK contents immediately; outputs take reset values in the same cycle.
- Latency: an entry accepted at edge k is presented on dout with out_valid=1 after edge k, available for fire at edge k+1.
- Throughput: 1 word/cycle with out_ready held high.
- Backpressure: after out_ready drops, at most one further word is accepted (into SK). in_ready is 0 from the following cycle until a fire occurs.
- Simultaneous accept and fire in TWO cannot occur, because in_ready=0.
- The NIN=2 boundary uses SELW=1. The NIN=16 boundary has no out-of-range codes.

## Test plan
- Reset/idle: reset_n=0 with random inputs → out_valid=0, in_ready=1, dout=0, rr_ptr=0. Release with in_valid=0 → outputs unchanged.
- Streaming, NIN=3, WIDTH=16: din={C=0x3333, B=0x2222, A=0x1111}, sel sequence 0,1,2,1 every cycle, out_ready=1 → dout 0x1111, 0x2222, 0x3333, 0x2222 on consecutive cycles, one cycle after each accept, out_err=0.
- Out-of-range: sel=3 (NIN=3) accepted → dout=0x0000, out_sel=3, out_err=1. Next accept with sel=0 → out_err=0.
- Round-robin: rr_mode=1, 5 accepts → out_sel 0,1,2,0,1 with matching data. Switch to rr_mode=0 for 2 accepts, then back to rr_mode=1 → next out_sel=2.
- Backpressure: stream with out_ready=0 from cycle 3 → exactly one extra accept, then in_ready=0 and dout stable. out_ready=1 → both held words emerge in order, then in_ready=1. Random valid/ready for 10k cycles against a scoreboard → no loss, no reorder, no duplicates.
- Reset mid-operation in state TWO → out_valid=0 and in_ready=1 immediately. The first post-reset accept appears with rr_ptr restarting at 0.

Source files
------------

// File: rtl/mux_sel_pipe_if.sv
// Operand-selector bus: upstream words plus select controls in, selected word and tag out.
// Also carries read-only debug views of the occupancy state and round-robin pointer.
interface mux_sel_pipe_if #(
    parameter int WIDTH = 16,
    parameter int NIN   = 3
);
    localparam int SELW = $clog2(NIN);

    logic [NIN*WIDTH-1:0] din;
    logic [SELW-1:0]      sel;
    logic                 rr_mode;
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     dout;
    logic [SELW-1:0]      out_sel;
    logic                 out_err;
    logic                 out_valid;
    logic                 out_ready;
    logic [1:0]           dbg_state;
    logic [SELW-1:0]      dbg_rr_ptr;

    // valid/ready: a word moves on a rising edge where valid and ready are both 1;
    // valid and its payload stay stable until that edge, and ready never depends on valid.
    modport master (
        output din, sel, rr_mode, in_valid, out_ready,
        input  in_ready, dout, out_sel, out_err, out_valid, dbg_state, dbg_rr_ptr
    );

    modport slave (
        input  din, sel, rr_mode, in_valid, out_ready,
        output in_ready, dout, out_sel, out_err, out_valid, dbg_state, dbg_rr_ptr
    );
endinterface

// File: rtl/mux_sel_pipe.sv
// Registered NIN:1 operand selector with a two-entry skid buffer, round-robin mode
// and out-of-range select flagging.
module mux_sel_pipe #(
    parameter int WIDTH = 16,
    parameter int NIN   = 3
) (
    input  logic          clk,
    input  logic          reset_n,
    mux_sel_pipe_if.slave bus
);
    localparam int              SELW  = $clog2(NIN);
    localparam logic [SELW:0]   NIN_L = (SELW+1)'(NIN);
    localparam logic [SELW-1:0] LAST  = SELW'(NIN-1);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] or_data_q, or_data_d;
    logic [SELW-1:0]  or_sel_q, or_sel_d;
    logic             or_err_q, or_err_d;
    logic [WIDTH-1:0] sk_data_q, sk_data_d;
    logic [SELW-1:0]  sk_sel_q, sk_sel_d;
    logic             sk_err_q, sk_err_d;
    logic [SELW-1:0]  rr_ptr_q, rr_ptr_d;
    logic             out_valid_q, out_valid_d;
    logic             in_ready_q, in_ready_d;

    logic             accept;
    logic             fire;
    logic [SELW-1:0]  eff;
    logic [WIDTH-1:0] new_data;
    logic             new_err;

    always_comb begin
        accept = bus.in_valid & in_ready_q;
        fire   = out_valid_q & bus.out_ready;
        eff    = bus.rr_mode ? rr_ptr_q : bus.sel;

        // Unmatched (out-of-range) codes leave the word at zero.
        new_data = '0;
        for (int i = 0; i < NIN; i++) begin
            if (eff == SELW'(i)) new_data = bus.din[i*WIDTH +: WIDTH];
        end
        new_err = ~bus.rr_mode & ({1'b0, eff} >= NIN_L);

        state_d   = state_q;
        or_data_d = or_data_q;
        or_sel_d  = or_sel_q;
        or_err_d  = or_err_q;
        sk_data_d = sk_data_q;
        sk_sel_d  = sk_sel_q;
        sk_err_d  = sk_err_q;
        rr_ptr_d  = rr_ptr_q;

        if (accept && bus.rr_mode) begin
            rr_ptr_d = (rr_ptr_q == LAST) ? '0 : rr_ptr_q + SELW'(1);
        end

        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    or_data_d = new_data;
                    or_sel_d  = eff;
                    or_err_d  = new_err;
                    state_d   = ST_ONE;
                end
            end
            ST_ONE: begin
                if (accept && fire) begin
                    or_data_d = new_data;
                    or_sel_d  = eff;
                    or_err_d  = new_err;
                end else if (accept) begin
                    sk_data_d = new_data;
                    sk_sel_d  = eff;
                    sk_err_d  = new_err;
                    state_d   = ST_TWO;
                end else if (fire) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (fire) begin
                    or_data_d = sk_data_q;
                    or_sel_d  = sk_sel_q;
                    or_err_d  = sk_err_q;
                    state_d   = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase

        // Handshake flags are registered copies of the next occupancy, so in_ready
        // has no combinational path from out_ready.
        out_valid_d = (state_d != ST_EMPTY);
        in_ready_d  = (state_d != ST_TWO);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_EMPTY;
            or_data_q   <= '0;
            or_sel_q    <= '0;
            or_err_q    <= 1'b0;
            sk_data_q   <= '0;
            sk_sel_q    <= '0;
            sk_err_q    <= 1'b0;
            rr_ptr_q    <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            or_data_q   <= or_data_d;
            or_sel_q    <= or_sel_d;
            or_err_q    <= or_err_d;
            sk_data_q   <= sk_data_d;
            sk_sel_q    <= sk_sel_d;
            sk_err_q    <= sk_err_d;
            rr_ptr_q    <= rr_ptr_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign bus.dout       = or_data_q;
    assign bus.out_sel    = or_sel_q;
    assign bus.out_err    = or_err_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.in_ready   = in_ready_q;
    assign bus.dbg_state  = state_q;
    assign bus.dbg_rr_ptr = rr_ptr_q;
endmodule

// File: tb/tb_mux_sel_pipe.sv
// Self-checking bench for mux_sel_pipe: queue-based reference model with a per-cycle
// compare, directed phases pinned by literal expectations, and a long random run.
module tb_mux_sel_pipe;
    localparam int WIDTH = 16;
    localparam int NIN   = 3;
    localparam int SELW  = $clog2(NIN);
    localparam int EW    = WIDTH + SELW + 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    mux_sel_pipe_if #(.WIDTH(WIDTH), .NIN(NIN)) ifc ();

    mux_sel_pipe #(.WIDTH(WIDTH), .NIN(NIN)) dut (
        .clk     (clk),
        .reset_n (rst_n),
        .bus     (ifc)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int               chk_cnt = 0;
    int               err_cnt = 0;
    logic [EW-1:0]    exp_q[$];
    logic [EW-1:0]    got_q[$];
    int               model_rr = 0;
    bit               fresh = 1'b1;
    bit               acc_s = 1'b0;
    bit               fire_s = 1'b0;
    logic [NIN*WIDTH-1:0] din_s;
    logic [SELW-1:0]  sel_s;
    logic             rr_s;
    int               acc_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [EW-1:0] ref_entry(input logic [NIN*WIDTH-1:0] d,
                                                input logic [SELW-1:0] s,
                                                input logic rr, input int ptr);
        int               eff;
        logic [WIDTH-1:0] w;
        logic             e;
        eff = rr ? ptr : int'(s);
        e   = (eff >= NIN);
        w   = e ? '0 : d[eff*WIDTH +: WIDTH];
        return {w, eff[SELW-1:0], e};
    endfunction

    // Reference model: occupancy is the queue length, entries leave in arrival order.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
            model_rr <= 0;
            fresh    <= 1'b1;
        end else begin
            if (fire_s) void'(exp_q.pop_front());
            if (acc_s) begin
                exp_q.push_back(ref_entry(din_s, sel_s, rr_s, model_rr));
                acc_total <= acc_total + 1;
                fresh     <= 1'b0;
                if (rr_s) model_rr <= (model_rr + 1) % NIN;
            end
        end
    end

    // Compare process: outputs are sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_out_valid", 64'(ifc.out_valid), 64'd0);
            check("rst_in_ready", 64'(ifc.in_ready), 64'd1);
            check("rst_dout", 64'(ifc.dout), 64'd0);
            check("rst_out_sel", 64'(ifc.out_sel), 64'd0);
            check("rst_out_err", 64'(ifc.out_err), 64'd0);
            check("rst_rr_ptr", 64'(ifc.dbg_rr_ptr), 64'd0);
            acc_s  = 1'b0;
            fire_s = 1'b0;
        end else begin
            check("out_valid", 64'(ifc.out_valid), 64'(exp_q.size() > 0));
            check("in_ready", 64'(ifc.in_ready), 64'(exp_q.size() < 2));
            check("rr_ptr", 64'(ifc.dbg_rr_ptr), 64'(model_rr));
            if (exp_q.size() > 0)
                check("head", 64'({ifc.dout, ifc.out_sel, ifc.out_err}), 64'(exp_q[0]));
            else if (fresh)
                check("idle_dout", 64'(ifc.dout), 64'd0);
            acc_s  = ifc.in_valid && (exp_q.size() < 2);
            fire_s = (exp_q.size() > 0) && ifc.out_ready;
            din_s  = ifc.din;
            sel_s  = ifc.sel;
            rr_s   = ifc.rr_mode;
            if (fire_s) got_q.push_back({ifc.dout, ifc.out_sel, ifc.out_err});
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int s, input bit rr);
        int  n;
        bit  take;
        ifc.in_valid = 1'b1;
        ifc.sel      = SELW'(s);
        ifc.rr_mode  = rr;
        n = 0;
        take = 1'b0;
        while (n < 50 && !take) begin
            take = ifc.in_ready;
            cyc();
            n++;
        end
        if (!take) check("send_timeout", 64'd1, 64'd0);
    endtask

    task automatic drain();
        int n;
        ifc.in_valid  = 1'b0;
        ifc.out_ready = 1'b1;
        n = 0;
        while (n < 50 && exp_q.size() > 0) begin
            cyc();
            n++;
        end
        if (exp_q.size() > 0) check("drain_timeout", 64'(exp_q.size()), 64'd0);
        cyc();
    endtask

    task automatic check_got(input string name, input int idx, input logic [WIDTH-1:0] d,
                             input int s, input bit e);
        logic [EW-1:0] exp_v;
        exp_v = {d, s[SELW-1:0], e};
        if (idx < got_q.size()) check(name, 64'(got_q[idx]), 64'(exp_v));
        else check({name, "_missing"}, 64'(got_q.size()), 64'(idx + 1));
    endtask

    // ---------------- stimulus ----------------
    logic [NIN*WIDTH-1:0] din_fixed;
    int                   a1;

    initial begin
        din_fixed     = {16'h3333, 16'h2222, 16'h1111};
        ifc.din       = {$urandom(), $urandom()};
        ifc.sel       = SELW'($urandom_range(0, 3));
        ifc.rr_mode   = 1'($urandom_range(0, 1));
        ifc.in_valid  = 1'b1;
        ifc.out_ready = 1'b1;

        // Reset with random inputs, then release idle.
        repeat (3) cyc();
        rst_n = 1'b1;
        ifc.in_valid = 1'b0;
        ifc.din      = din_fixed;
        repeat (2) cyc();
        check("idle_out_valid", 64'(ifc.out_valid), 64'd0);
        check("idle_in_ready", 64'(ifc.in_ready), 64'd1);
        check("idle_dout0", 64'(ifc.dout), 64'd0);

        // Streaming explicit selects.
        got_q.delete();
        send(0, 0); send(1, 0); send(2, 0); send(1, 0);
        drain();
        check("stream_count", 64'(got_q.size()), 64'd4);
        check_got("stream0", 0, 16'h1111, 0, 1'b0);
        check_got("stream1", 1, 16'h2222, 1, 1'b0);
        check_got("stream2", 2, 16'h3333, 2, 1'b0);
        check_got("stream3", 3, 16'h2222, 1, 1'b0);

        // Out-of-range select.
        got_q.delete();
        send(3, 0); send(0, 0);
        drain();
        check_got("oor_err", 0, 16'h0000, 3, 1'b1);
        check_got("oor_clear", 1, 16'h1111, 0, 1'b0);

        // Round-robin with a mode excursion.
        got_q.delete();
        for (int i = 0; i < 5; i++) send(0, 1);
        send(0, 0); send(0, 0);
        send(0, 1);
        drain();
        check_got("rr0", 0, 16'h1111, 0, 1'b0);
        check_got("rr1", 1, 16'h2222, 1, 1'b0);
        check_got("rr2", 2, 16'h3333, 2, 1'b0);
        check_got("rr3", 3, 16'h1111, 0, 1'b0);
        check_got("rr4", 4, 16'h2222, 1, 1'b0);
        check_got("rr_resume", 7, 16'h3333, 2, 1'b0);

        // Backpressure: ready drops after three streamed words.
        got_q.delete();
        ifc.rr_mode   = 1'b0;
        ifc.in_valid  = 1'b1;
        ifc.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ifc.sel = SELW'(i);
            cyc();
        end
        ifc.out_ready = 1'b0;
        ifc.sel       = SELW'(1);
        a1 = acc_total;
        repeat (5) cyc();
        check("bp_extra_accepts", 64'(acc_total - a1), 64'd1);
        check("bp_in_ready", 64'(ifc.in_ready), 64'd0);
        check("bp_dout_held", 64'(ifc.dout), 64'h3333);
        drain();
        check("bp_count", 64'(got_q.size()), 64'd4);
        check_got("bp_or", 2, 16'h3333, 2, 1'b0);
        check_got("bp_sk", 3, 16'h2222, 1, 1'b0);
        check("bp_ready_back", 64'(ifc.in_ready), 64'd1);

        // Random valid/ready traffic.
        for (int i = 0; i < 10000; i++) begin
            ifc.in_valid  = ($urandom_range(0, 3) != 0);
            ifc.out_ready = ($urandom_range(0, 2) != 0);
            ifc.sel       = SELW'($urandom_range(0, 3));
            ifc.rr_mode   = ($urandom_range(0, 3) == 0);
            ifc.din       = {$urandom(), $urandom()};
            cyc();
        end
        drain();
        check("rand_empty", 64'(exp_q.size()), 64'd0);

        // Reset while two entries are held, with a non-zero round-robin pointer.
        ifc.din = din_fixed;
        send(0, 1);
        drain();
        ifc.out_ready = 1'b0;
        ifc.in_valid  = 1'b1;
        ifc.rr_mode   = 1'b0;
        ifc.sel       = SELW'(0);
        repeat (3) cyc();
        check("two_in_ready", 64'(ifc.in_ready), 64'd0);
        check("two_out_valid", 64'(ifc.out_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 64'(ifc.out_valid), 64'd0);
        check("midrst_in_ready", 64'(ifc.in_ready), 64'd1);
        check("midrst_rr_ptr", 64'(ifc.dbg_rr_ptr), 64'd0);
        cyc();
        rst_n = 1'b1;
        ifc.in_valid  = 1'b0;
        ifc.out_ready = 1'b1;
        cyc();
        got_q.delete();
        send(2, 1);
        drain();
        check_got("post_rst_rr", 0, 16'h1111, 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", chk_cnt, err_cnt);
        $finish;
    end
endmodule
